// File: rtl/mips32_mem_pkg.sv
// Shared types and constants for the MIPS32 data-memory responder.
package mips32_mem_pkg;

  localparam int unsigned DATA_W         = 32;
  localparam int unsigned DEFAULT_ADDR_W = 10;

  // One response as it travels through the latency pipeline and the response FIFO.
  typedef struct packed {
    logic              we;
    logic              err;
    logic [DATA_W-1:0] rdata;
  } rsp_entry_t;

endpackage

// File: rtl/mips32_rsp_fifo.sv
// Synchronous response FIFO. Full/empty come from an occupancy count, not pointer equality.
// The head shows the last popped entry while empty so outputs hold their value.
module mips32_rsp_fifo
  import mips32_mem_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            push_i,
  input  rsp_entry_t      push_data_i,
  input  logic            pop_i,
  output logic            valid_o,
  output rsp_entry_t      head_o,
  output logic [CntW-1:0] count_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  rsp_entry_t      mem_q [DEPTH];
  rsp_entry_t      hold_q;
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign do_pop = pop_i && (count_q != '0);

  // Pointer, occupancy and hold-register update; the producer never pushes when full.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      hold_q   <= '0;
    end else begin
      if (push_i) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
        hold_q   <= mem_q[rd_ptr_q];
      end
      count_q <= count_q + CntW'(push_i) - CntW'(do_pop);
    end
  end

  // Entry storage, no reset needed since only counted entries are ever shown.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign valid_o = (count_q != '0);
  assign head_o  = valid_o ? mem_q[rd_ptr_q] : hold_q;
  assign count_o = count_q;

endmodule

// File: rtl/mips32_dmem_responder.sv
// Data-memory responder: valid/ready request channel, fixed-latency pipeline, credit-limited
// response FIFO. Optional address range checking is enabled by defining DMEM_ADDR_CHECK_EN.
module mips32_dmem_responder
  import mips32_mem_pkg::*;
#(
  parameter int unsigned ADDR_W    = DEFAULT_ADDR_W,
  parameter int unsigned MEM_WORDS = 1024,
  parameter int unsigned RD_LAT    = 2,
  parameter int unsigned RSP_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_we,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int unsigned IdxW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int unsigned CntW = $clog2(RSP_DEPTH + 1);

  logic [DATA_W-1:0] mem_q [MEM_WORDS];
  logic [IdxW-1:0]   idx;
  logic              addr_err;
  logic              acc, pop;
  logic [CntW-1:0]   outstanding_q, outstanding_d;
  logic              req_ready_q;
  logic [RD_LAT-1:0] pv_q;
  rsp_entry_t        pe_q [RD_LAT];
  rsp_entry_t        st_entry;
  rsp_entry_t        head;
  logic [CntW-1:0]   unused_fifo_cnt;
  logic              unused_addr;
  logic              unused_err;

  assign idx = req_addr[IdxW-1:0];

`ifdef DMEM_ADDR_CHECK_EN
  assign addr_err = (64'(req_addr) >= 64'(MEM_WORDS));
`else
  assign addr_err = 1'b0;
`endif

  // Reset gates acceptance so no store commits on a reset edge.
  assign acc = req_valid && req_ready_q && !rst;
  assign pop = rsp_valid && rsp_ready;

  // Credits cover both the pipeline and the FIFO, so the FIFO cannot overflow.
  assign outstanding_d = outstanding_q + CntW'(acc) - CntW'(pop);

  // Outstanding credit counter and registered ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding_q <= '0;
      req_ready_q   <= 1'b0;
    end else begin
      outstanding_q <= outstanding_d;
      req_ready_q   <= (outstanding_d < CntW'(RSP_DEPTH));
    end
  end

  assign req_ready = req_ready_q;

  // Stores commit at the accept edge; out-of-range stores are dropped when checking is on.
  always_ff @(posedge clk) begin
    if (acc && req_we && !addr_err) mem_q[idx] <= req_wdata;
  end

  // Loads see stores from earlier edges since the array is read before this edge's write.
  always_comb begin
    st_entry       = '0;
    st_entry.we    = req_we;
    st_entry.err   = addr_err;
    st_entry.rdata = (req_we || addr_err) ? '0 : mem_q[idx];
  end

  // Latency pipeline valid bits; clearing these discards in-flight responses on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pv_q <= '0;
    end else begin
      pv_q[0] <= acc;
      for (int unsigned i = 1; i < RD_LAT; i++) pv_q[i] <= pv_q[i-1];
    end
  end

  // Latency pipeline payload.
  always_ff @(posedge clk) begin
    pe_q[0] <= st_entry;
    for (int unsigned i = 1; i < RD_LAT; i++) pe_q[i] <= pe_q[i-1];
  end

  mips32_rsp_fifo #(
    .DEPTH(RSP_DEPTH)
  ) u_rsp_fifo (
    .clk_i       (clk),
    .rst_i       (rst),
    .push_i      (pv_q[RD_LAT-1]),
    .push_data_i (pe_q[RD_LAT-1]),
    .pop_i       (pop),
    .valid_o     (rsp_valid),
    .head_o      (head),
    .count_o     (unused_fifo_cnt)
  );

  assign rsp_we    = head.we;
  assign rsp_rdata = head.rdata;

`ifdef DMEM_ADDR_CHECK_EN
  assign rsp_err    = head.err;
  assign unused_err = 1'b0;
`else
  assign rsp_err    = 1'b0;
  assign unused_err = head.err;
`endif

  // Upper address bits are intentionally ignored when the address is truncated.
  assign unused_addr = ^req_addr;

endmodule

// File: doc/mips32_dmem_responder.md
Name: mips32_dmem_responder

Overview:
- Word-addressed data-memory responder: the target end of the pipeline's load/store memory interface.
- Accepts one request per cycle on a valid/ready request channel (read or write) and commits writes at acceptance.
- Returns in-order responses on a valid/ready response channel after a fixed read latency, buffered by a response FIFO with credit-based backpressure.
- Sits between the processor's MEM stage and the data-memory array.

Parameters:
- ADDR_W, 10, request address width in words.
- MEM_WORDS, 1024, number of 32-bit words implemented; must be <= 2**ADDR_W.
- RD_LAT, 2, request-accept to response-valid latency in cycles; must be >= 1.
- RSP_DEPTH, 4, response FIFO depth; also the maximum number of outstanding requests; must be >= 1.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  32  store data.
- rsp_valid  out  1  response present at FIFO head.
- rsp_ready  in  1  initiator consumes the response.
- rsp_we  out  1  echo of req_we for this response.
- rsp_rdata  out  32  load data; 0 for stores.
- rsp_err  out  1  address error (only with the optional feature; tied 0 otherwise).

Behaviour:
- Reset: the interface is one clock (clk) with a synchronous, active-high reset (rst). While rst=1 at an edge:
  - req_ready=0, rsp_valid=0, rsp_we=0, rsp_rdata=0, rsp_err=0.
  - The outstanding counter, latency pipeline and FIFO pointers are cleared.
  - Memory contents are not reset.
  - req_ready is 1 from the first cycle after rst deasserts.
- Accept: a request is accepted at an edge where req_valid && req_ready. At most one request per edge.
- req_ready = !rst_q && (outstanding < RSP_DEPTH), registered.
  - outstanding counts accepted requests not yet popped (in the pipeline plus in the FIFO).
- Store: MEM[req_addr] <= req_wdata at the accept edge. A response with rsp_we=1 and rsp_rdata=0 follows the same latency path.
- Load: reads MEM[req_addr] after any store committed at an earlier edge. Read-after-write back-to-back returns the new data.
- Latency: for a request accepted at edge e0 with the FIFO empty, rsp_valid=1 in the cycle after edge e0+RD_LAT.
  - The response travels through an RD_LAT-stage shift pipeline (valid bit, we, data, err) and then into the FIFO.
  - rsp_* is driven only from the FIFO head, never combinationally from req_*.
- Pop: at an edge where rsp_valid && rsp_ready. rsp_* must stay stable while rsp_valid && !rsp_ready.
- Simultaneous accept and pop at the same edge: outstanding is unchanged and req_ready is unchanged.
- Full: when outstanding == RSP_DEPTH, req_ready=0. The FIFO can never overflow, because credits cover pipeline occupancy.
- Empty: rsp_valid=0, and rsp_rdata/rsp_we/rsp_err hold their last values.
- Pointer wrap: FIFO pointers wrap modulo RSP_DEPTH. Full and empty are distinguished by a count, not by pointer equality.
- Ordering: responses are strictly in acceptance order.
- Reset mid-operation: all in-flight and buffered responses are discarded and none are emitted after reset. A store accepted before reset remains committed.

Optional Feature:
- Macro DMEM_ADDR_CHECK_EN.
- Defined:
  - A request with req_addr >= MEM_WORDS is accepted normally, but a store does not write memory.
  - Its response carries rsp_err=1 and rsp_rdata=0.
- Undefined:
  - The address is reduced modulo MEM_WORDS by truncation to clog2(MEM_WORDS) bits.
  - rsp_err is constant 0.

Decomposition:
- Package mips32_mem_pkg:
  - Constants DATA_W=32 and default ADDR_W.
  - Packed struct rsp_entry_t {we, err, rdata[31:0]} shared by the pipeline and FIFO.
- One natural sub-module: mips32_rsp_fifo, a synchronous FIFO of rsp_entry_t with push/pop/count, RSP_DEPTH deep.

Test Plan:
- Single load: preload MEM[5]=0xDEADBEEF, rsp_ready=1, issue a load at addr 5 -> rsp_valid exactly RD_LAT cycles later with rdata=0xDEADBEEF, we=0.
- Store then load back-to-back: store 0x12345678 to addr 9, load addr 9 on the next edge -> second response rdata=0x12345678; first response we=1, rdata=0.
- Backpressure: rsp_ready=0, issue loads to addrs 0..5 holding req_valid -> exactly RSP_DEPTH (4) accepted and req_ready=0; release rsp_ready -> responses for addrs 0..3 in order, then addrs 4,5 accepted and returned.
- Full with simultaneous pop: FIFO full, rsp_ready=1 and req_valid=1 every cycle -> one accept and one pop per edge in steady state, no drops or duplicates over 20 requests.
- Reset mid-flight: 3 loads outstanding, rst=1 for 1 cycle -> rsp_valid=0 from the next cycle, no stale responses, req_ready=1 after reset.
- With DMEM_ADDR_CHECK_EN and MEM_WORDS=512: store 0xAAAA to addr 600 -> rsp_err=1, memory unchanged; without the macro -> MEM[88] written, rsp_err=0.
